// File: rtl/radix4_sdf_buffer_ctrl.sv
// Sequencer for a single radix-4 SDF stage delay buffer.
// It accepts D/4 groups of four butterfly outputs and then drains the buffer
// one sample per accepted beat. The split flavours (MODE 0/1) insert a one-cycle
// rotate between the two drain phases. The plain and short flavours (MODE 2/3)
// drain in a single phase.
module radix4_sdf_buffer_ctrl #(
  parameter int DEPTH = 16,
  parameter int MODE  = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic out_ready,
  output logic out_valid,
  output logic enable_write,
  output logic enable_read_first,
  output logic enable_read_last,
  output logic rotate,
  output logic busy,
  output logic frame_done
);

  localparam int Q  = DEPTH / 4;
  localparam int WW = $clog2(Q) + 1;
  localparam int RW = $clog2(DEPTH) + 1;

  // Reads before the rotate (R1) and after it (R2) for each buffer flavour.
  localparam int R1 = (MODE == 0) ? DEPTH / 2 :
                      (MODE == 2) ? DEPTH     : (3 * DEPTH) / 4;
  localparam int R2 = (MODE == 0) ? DEPTH / 2 :
                      (MODE == 1) ? DEPTH / 4 : 0;
  localparam bit HAS_ROT = (R2 > 0);

  localparam logic [WW-1:0] W_LAST  = WW'(Q - 1);
  localparam logic [RW-1:0] R1_LAST = RW'(R1 - 1);
  localparam logic [RW-1:0] R2_LAST = RW'((R2 > 0) ? R2 - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN_FIRST,
    S_ROTATE,
    S_DRAIN_LAST
  } state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   wcnt, wcnt_nxt;
  logic [RW-1:0]   rcnt, rcnt_nxt;
  logic            done_q, done_nxt;
  logic            abort;

  // A reset, or a flush that arrives in the middle of a frame, kills the
  // current cycle's strobes and sends the controller back to idle.
  assign abort = reset | (flush & (state != S_IDLE));

  // Register the state, the counters and the frame-done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      rcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wcnt   <= wcnt_nxt;
      rcnt   <= rcnt_nxt;
      done_q <= done_nxt;
    end
  end

  // Decode the strobes from the registered state and compute the next state.
  always_comb begin
    state_nxt         = state;
    wcnt_nxt          = wcnt;
    rcnt_nxt          = rcnt;
    done_nxt          = 1'b0;
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    enable_read_first = 1'b0;
    enable_read_last  = 1'b0;
    rotate            = 1'b0;

    unique case (state)
      S_IDLE, S_FILL: in_ready = 1'b1;
      S_DRAIN_FIRST: begin
        out_valid         = 1'b1;
        enable_read_first = out_ready;
      end
      S_ROTATE:       rotate = HAS_ROT;
      S_DRAIN_LAST: begin
        out_valid        = HAS_ROT;
        enable_read_last = HAS_ROT & out_ready;
      end
      default: ;
    endcase

    if (abort) begin
      in_ready          = 1'b0;
      out_valid         = 1'b0;
      enable_read_first = 1'b0;
      enable_read_last  = 1'b0;
      rotate            = 1'b0;
      state_nxt         = S_IDLE;
      wcnt_nxt          = '0;
      rcnt_nxt          = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (Q == 1) begin
              state_nxt = S_DRAIN_FIRST;
              wcnt_nxt  = '0;
            end else begin
              state_nxt = S_FILL;
              wcnt_nxt  = WW'(1);
            end
            rcnt_nxt = '0;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            if (wcnt == W_LAST) begin
              state_nxt = S_DRAIN_FIRST;
              wcnt_nxt  = '0;
              rcnt_nxt  = '0;
            end else begin
              wcnt_nxt = wcnt + 1'b1;
            end
          end
        end
        S_DRAIN_FIRST: begin
          if (out_ready) begin
            if (rcnt == R1_LAST) begin
              rcnt_nxt = '0;
              if (HAS_ROT) begin
                state_nxt = S_ROTATE;
              end else begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
              end
            end else begin
              rcnt_nxt = rcnt + 1'b1;
            end
          end
        end
        S_ROTATE: begin
          state_nxt = S_DRAIN_LAST;
          rcnt_nxt  = '0;
        end
        S_DRAIN_LAST: begin
          if (out_ready) begin
            if (rcnt == R2_LAST) begin
              state_nxt = S_IDLE;
              rcnt_nxt  = '0;
              done_nxt  = 1'b1;
            end else begin
              rcnt_nxt = rcnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
          wcnt_nxt  = '0;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign enable_write = in_valid & in_ready;
  assign busy         = ~reset & (state != S_IDLE);
  assign frame_done   = done_q & ~reset;

endmodule

// File: tb/tb_radix4_sdf_buffer_ctrl.sv
// Bench for radix4_sdf_buffer_ctrl. It runs four instances side by side:
// instance k has MODE k, and the depth is 16, except that instance 3 uses 64.
// A transaction-count reference model predicts every instance's output
// vector each cycle. A monitor compares the DUT outputs against that model.
module tb_radix4_sdf_buffer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic flush_v [4];
  logic iv_v    [4];
  logic ordy_v  [4];
  logic irdy [4], ov [4], ew [4], erf [4], erl [4], rot [4], bsy [4], fd [4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      radix4_sdf_buffer_ctrl #(
        .DEPTH((g == 3) ? 64 : 16),
        .MODE (g)
      ) u_dut (
        .clock            (clk),
        .reset            (reset),
        .flush            (flush_v[g]),
        .in_valid         (iv_v[g]),
        .in_ready         (irdy[g]),
        .out_ready        (ordy_v[g]),
        .out_valid        (ov[g]),
        .enable_write     (ew[g]),
        .enable_read_first(erf[g]),
        .enable_read_last (erl[g]),
        .rotate           (rot[g]),
        .busy             (bsy[g]),
        .frame_done       (fd[g])
      );
    end
  endgenerate

  // Stimulus requested for the next cycle
  logic s_rst;
  logic s_iv [4], s_or [4], s_fl [4];

  typedef struct {
    int         k;
    logic [7:0] v;   // {in_ready,out_valid,wr,rd_first,rd_last,rotate,busy,frame_done}
  } sb_ent_t;
  sb_ent_t sbq [$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: the number of groups written, the number of samples
  // read, whether the rotate has happened, and the registered done pulse
  int mw [4];
  int mr [4];
  bit mrot [4];
  bit mfd [4];

  // DUT-observed activity counters (written only by the monitor)
  int n_ew [4], n_erf [4], n_erl [4], n_rot [4], n_fd [4], n_xf [4], n_fdew [4], fd_cyc [4];
  int b_ew, b_erf, b_erl, b_rot, b_fd, b_xf, b_fdew;

  function automatic int dep(input int k);
    return (k == 3) ? 64 : 16;
  endfunction

  function automatic int r1(input int k);
    case (k)
      0: return dep(k) / 2;
      1: return 3 * dep(k) / 4;
      2: return dep(k);
      default: return 3 * dep(k) / 4;
    endcase
  endfunction

  function automatic int r2(input int k);
    case (k)
      0: return dep(k) / 2;
      1: return dep(k) / 4;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model step for one instance: it predicts the outputs for this cycle and
  // advances the transaction counts.
  task automatic model_step(input int k, input logic iv, input logic ordy,
                            input logic fl, input logic rs, output logic [7:0] e);
    int   q, n1, n2;
    logic bz, acc, df, rc, dl, w_ev, rd_ev;
    q  = dep(k) / 4;
    n1 = r1(k);
    n2 = r2(k);
    e  = '0;
    if (rs) begin
      mw[k] = 0; mr[k] = 0; mrot[k] = 0; mfd[k] = 0;
    end else begin
      bz  = (mw[k] > 0);
      acc = (mw[k] < q);
      df  = (mw[k] == q) && (mr[k] < n1);
      rc  = (mw[k] == q) && (mr[k] == n1) && (n2 > 0) && !mrot[k];
      dl  = mrot[k];
      e[1] = bz;
      e[0] = mfd[k];
      if (fl && bz) begin
        mw[k] = 0; mr[k] = 0; mrot[k] = 0; mfd[k] = 0;
      end else begin
        w_ev  = acc && iv;
        rd_ev = (df || dl) && ordy;
        e[7] = acc;
        e[6] = df || dl;
        e[5] = w_ev;
        e[4] = df && ordy;
        e[3] = dl && ordy;
        e[2] = rc;
        mfd[k] = 0;
        if (w_ev) mw[k]++;
        if (rc) mrot[k] = 1;
        if (rd_ev) begin
          mr[k]++;
          if (mr[k] == n1 + n2) begin
            mw[k] = 0; mr[k] = 0; mrot[k] = 0; mfd[k] = 1;
          end
        end
      end
    end
  endtask

  // Apply one cycle of stimulus on the falling edge and queue the expected outputs.
  task automatic tick();
    sb_ent_t    ent;
    logic [7:0] e;
    @(negedge clk);
    reset = s_rst;
    for (int k = 0; k < 4; k++) begin
      iv_v[k]    = s_iv[k];
      ordy_v[k]  = s_or[k];
      flush_v[k] = s_fl[k];
    end
    cyc++;
    for (int k = 0; k < 4; k++) begin
      model_step(k, s_iv[k], s_or[k], s_fl[k], s_rst, e);
      ent.k = k;
      ent.v = e;
      sbq.push_back(ent);
    end
  endtask

  task automatic clr_stim();
    s_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_iv[k] = 1'b0; s_or[k] = 1'b0; s_fl[k] = 1'b0;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int k);
    settle();
    b_ew = n_ew[k]; b_erf = n_erf[k]; b_erl = n_erl[k]; b_rot = n_rot[k];
    b_fd = n_fd[k]; b_xf = n_xf[k]; b_fdew = n_fdew[k];
  endtask

  task automatic agg(input int k, input string p, input int x_ew, input int x_erf,
                     input int x_erl, input int x_rot, input int x_fd, input int x_xf);
    settle();
    chk({p, "_writes"},    n_ew[k]  - b_ew,  x_ew);
    chk({p, "_rd_first"},  n_erf[k] - b_erf, x_erf);
    chk({p, "_rd_last"},   n_erl[k] - b_erl, x_erl);
    chk({p, "_rotates"},   n_rot[k] - b_rot, x_rot);
    chk({p, "_frame_done"}, n_fd[k] - b_fd,  x_fd);
    chk({p, "_out_xfers"}, n_xf[k]  - b_xf,  x_xf);
  endtask

  // One MODE 0 frame with continuous valid and ready, followed by an idle cycle.
  task automatic full_frame0(input string p);
    int start;
    snap(0);
    s_iv[0] = 1'b1;
    s_or[0] = 1'b1;
    tick();
    start = cyc;
    repeat (20) tick();
    s_iv[0] = 1'b0;
    tick();
    s_or[0] = 1'b0;
    tick();
    agg(0, p, 4, 8, 8, 1, 1, 16);
    chk({p, "_done_cycle"}, fd_cyc[0] - start + 1, 22);
  endtask

  // Monitor: sample away from the active edge, pop the predictions and compare.
  initial begin : monitor
    sb_ent_t    ent;
    int         k;
    logic [7:0] act;
    logic       bad;
    forever begin
      @(negedge clk);
      #2;
      while (sbq.size() > 0) begin
        ent = sbq.pop_front();
        k   = ent.k;
        act = {irdy[k], ov[k], ew[k], erf[k], erl[k], rot[k], bsy[k], fd[k]};
        n_checks++;
        if (act === ent.v) n_pass++;
        else $display("FAIL outputs inst%0d cyc%0d: got %b expected %b", k, cyc, act, ent.v);
        bad = ((32'(ew[k]) + 32'(erf[k]) + 32'(erl[k])) > 1) ||
              (rot[k] && (ew[k] || erf[k] || erl[k]));
        chk($sformatf("strobe_exclusive_inst%0d", k), int'(bad), 0);
        n_ew[k]  += int'(ew[k]);
        n_erf[k] += int'(erf[k]);
        n_erl[k] += int'(erl[k]);
        n_rot[k] += int'(rot[k]);
        n_fd[k]  += int'(fd[k]);
        n_xf[k]  += int'(ov[k] && ordy_v[k]);
        n_fdew[k] += int'(fd[k] && ew[k]);
        if (fd[k] === 1'b1) fd_cyc[k] = cyc;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    for (int k = 0; k < 4; k++) begin
      mw[k] = 0; mr[k] = 0; mrot[k] = 0; mfd[k] = 0;
      n_ew[k] = 0; n_erf[k] = 0; n_erl[k] = 0; n_rot[k] = 0;
      n_fd[k] = 0; n_xf[k] = 0; n_fdew[k] = 0; fd_cyc[k] = 0;
      iv_v[k] = 1'b0; ordy_v[k] = 1'b0; flush_v[k] = 1'b0;
    end
    reset = 1'b1;
    clr_stim();

    // Reset is held for two cycles while valid is offered. Then it is released.
    s_rst = 1'b1;
    s_iv[0] = 1'b1;
    repeat (2) tick();
    clr_stim();
    tick();
    #3;
    chk("rst_release_in_ready", int'(irdy[0]), 1);
    chk("rst_release_busy", int'(bsy[0]), 0);

    // MODE 0 with continuous flow
    full_frame0("m0_cont");

    // MODE 1 with out_ready toggling
    snap(1);
    for (int i = 0; i < 54; i++) begin
      s_iv[1] = (i < 4);
      s_or[1] = (i % 2 == 0);
      tick();
    end
    clr_stim();
    agg(1, "m1_toggle", 4, 12, 4, 1, 1, 16);

    // MODE 3 at depth 64 with two back-to-back frames
    snap(3);
    s_iv[3] = 1'b1;
    s_or[3] = 1'b1;
    repeat (128) tick();
    s_iv[3] = 1'b0;
    repeat (2) tick();
    clr_stim();
    agg(3, "m3_b2b", 32, 96, 0, 0, 2, 96);
    chk("m3_b2b_write_on_done", n_fdew[3] - b_fdew, 1);

    // MODE 0 with a flush on the third first-phase read
    snap(0);
    s_iv[0] = 1'b1;
    repeat (4) tick();
    s_iv[0] = 1'b0;
    s_or[0] = 1'b1;
    repeat (2) tick();
    s_fl[0] = 1'b1;
    tick();
    clr_stim();
    tick();
    #3;
    chk("flush_busy_next", int'(bsy[0]), 0);
    agg(0, "m0_flush", 4, 2, 0, 0, 0, 2);
    full_frame0("m0_after_flush");

    // MODE 0 with a reset during the fill, after two writes
    snap(0);
    s_iv[0] = 1'b1;
    repeat (2) tick();
    s_rst = 1'b1;
    tick();
    clr_stim();
    tick();
    #3;
    chk("rst_fill_in_ready", int'(irdy[0]), 1);
    agg(0, "m0_rst_fill", 2, 0, 0, 0, 0, 0);
    full_frame0("m0_after_rst");

    // MODE 2 with random gaps in in_valid during the fill
    snap(2);
    for (int i = 0; i < 60 && mw[2] < 4; i++) begin
      s_iv[2] = (i % 2 == 1) && ($urandom_range(3) != 0);
      s_or[2] = 1'b1;
      tick();
    end
    s_iv[2] = 1'b0;
    repeat (18) tick();
    clr_stim();
    agg(2, "m2_gaps", 4, 16, 0, 0, 1, 16);

    // Random run on all instances, with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) begin
        s_iv[k] = ($urandom_range(3) != 0);
        s_or[k] = ($urandom_range(2) != 0);
        s_fl[k] = ($urandom_range(96) == 0);
      end
      s_rst = ($urandom_range(999) == 0);
      tick();
    end
    clr_stim();
    repeat (3) tick();
    settle();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
